commit_arbiter: RTL and testbench
=================================

// Module: commit_arbiter
// PURPOSE
//  Commit stage downstream of the execution ALUs (alu0..alu4, incl. CSR ALU). Collects
//  finished results over the req/valid/clear commiter handshake, grants one per cycle
//  round-robin, writes it to the integer register file, raises exception reports for errored
//  results. One register-file write port; sole consumer of every ALU's commiter interface.
// PARAMETERS
//  NUM_SRC     5                          number of ALU result sources (>=2)
//  XLEN        core_config_pkg::XLEN      result width
//  REG_ADDR_W  core_config_pkg::REG_ADDR_W destination register index width
// PORTS
//  clk        in   1                   core clock
//  rst        in   1                   reset: one clock; synchronous, active-high
//  src_req    in   NUM_SRC             source has a result pending
//  src_valid  in   NUM_SRC             result fields of source are valid
//  src_res    in   NUM_SRC x XLEN      result data per source
//  src_rd     in   NUM_SRC x REG_ADDR_W destination register per source
//  src_error  in   NUM_SRC             source result carries an execution error
//  src_clear  out  NUM_SRC             one-cycle "consumed" pulse back to source
//  flush      in   1                   pipeline flush: discard all pending results
//  rf_we      out  1                   register-file write enable
//  rf_waddr   out  REG_ADDR_W          register-file write address
//  rf_wdata   out  XLEN                register-file write data
//  exc_valid  out  1                   errored result committed (one-cycle pulse)
//  exc_src    out  $clog2(NUM_SRC)     index of source that raised exc_valid
//  stall_cnt  out  32                  only with COMMIT_STALL_CNT_EN (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (rst=1 at edge): all outputs 0, rr_ptr=0, last_grant mask=0. Reset mid-transfer
//    discards the registered commit; no clear is issued for it.
//  - Eligible(i) = src_req[i] & src_valid[i] & ~last_grant[i]. last_grant masks the source
//    granted in previous cycle (its req is still high while it samples clear).
//  - Cycle N: pick first eligible i scanning rr_ptr, rr_ptr+1, ... mod NUM_SRC. Register grant.
//  - Cycle N+1 (latency 1): src_clear[g]=1 for exactly one cycle; if ~src_error[g] and
//    src_rd[g]!=0: rf_we=1, rf_waddr/rf_wdata = values sampled at N. rd==0: no write, clear
//    still issued. src_error[g]=1: rf_we=0, exc_valid=1, exc_src=g.
//  - rr_ptr <= (g+1) mod NUM_SRC on every grant; unchanged when none eligible.
//  - No eligible source: all outputs 0 next cycle; rr_ptr held.
//  - Throughput: one commit/cycle; one source can commit at most every 2 cycles.
//  - flush=1 at edge N: no grant; at N+1 src_clear = src_req sampled at N (all pending
//    dropped), rf_we=0, exc_valid=0, last_grant cleared, rr_ptr held. Flush over a
//    registered commit from N-1 still lets that commit complete at N (already ordered).
//  - Sources with src_req=1 & src_valid=0 are never granted and never cleared (except flush).
// CONFIGURATION
//  COMMIT_STALL_CNT_EN defined: 32-bit stall_cnt increments (wraps at 2^32-1 -> 0) each cycle
//    where >=1 source has req&valid but is not granted (lost arbitration or masked); reset 0,
//    held during flush. Not defined: stall_cnt port absent, no counter logic.
// STRUCTURE
//  - core_config_pkg: XLEN, REG_ADDR_W (existing); add COMMIT_NUM_SRC=5 and
//    commit_t struct {rd, data, error, src} used for the registered commit stage.
//  - One sub-module: rr_arbiter (NUM_SRC request vector + pointer -> one-hot grant + index),
//    purely combinational, reused later by the issuer.
// TESTING
//  1 Single: src2 req/valid, rd=5, res=0xDEADBEEF -> next cycle rf_we=1, waddr=5,
//    wdata=0xDEADBEEF, src_clear=5'b00100 for one cycle.
//  2 Contention: all 5 req from reset, held until cleared -> grants in order 0,1,2,3,4,
//    one per cycle; rr_ptr returns to 0.
//  3 Masking: src1 only, req held 3 cycles after clear -> granted cycles 1 and 3, not 2.
//  4 Error + x0: src3 error=1 rd=7 -> rf_we=0, exc_valid=1, exc_src=3; src0 rd=0 ->
//    rf_we=0, src_clear[0]=1.
//  5 Flush: src0,src4 pending, flush=1 -> next cycle src_clear=5'b10001, rf_we=0; rst=1
//    with a commit registered -> all outputs 0 next cycle.
//  6 COMMIT_STALL_CNT_EN: 3 sources pending 4 cycles -> stall_cnt increments each of those
//    cycles; preload 0xFFFFFFFF via force -> wraps to 0.

Source files
------------

// File: rtl/commit_arbiter_pkg.sv
// Shared types and sizing for the commit stage.
// Holds the core data-path widths, the number of ALU result sources and the
// record captured for a granted result between grant and register-file write.
package commit_arbiter_pkg;

  localparam int CORE_XLEN       = 32;
  localparam int CORE_REG_ADDR_W = 5;
  localparam int COMMIT_NUM_SRC  = 5;
  localparam int COMMIT_SRC_W    = $clog2(COMMIT_NUM_SRC);

  // One granted result, as it travels from the grant cycle to the write cycle.
  typedef struct packed {
    logic [CORE_REG_ADDR_W-1:0] rd;
    logic [CORE_XLEN-1:0]       data;
    logic                       error;
    logic [COMMIT_SRC_W-1:0]    src;
  } commit_t;

endpackage

// File: rtl/commit_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter.
// Scans the request vector starting at the pointer position and wrapping
// around; returns the first requester as a one-hot vector and as an index.
// Kept generic so the issue stage can reuse it.
module commit_arbiter_rr_arbiter #(
  parameter int N     = 5,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N-1:0]     o_gnt_oh,
  output logic [IDX_W-1:0] o_gnt_idx,
  output logic             o_gnt_any
);

  // Pick the first request found at or after the pointer, modulo N.
  always_comb begin
    logic [IDX_W-1:0] w_j;
    o_gnt_oh  = '0;
    o_gnt_idx = '0;
    o_gnt_any = 1'b0;
    w_j       = '0;
    for (int k = 0; k < N; k++) begin
      w_j = IDX_W'((int'(i_ptr) + k) % N);
      if (!o_gnt_any && i_req[w_j]) begin
        o_gnt_any     = 1'b1;
        o_gnt_idx     = w_j;
        o_gnt_oh[w_j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/commit_arbiter.sv
// Commit stage: collects finished ALU results over the req/valid/clear
// handshake, grants one per cycle round-robin, writes it to the integer
// register file one cycle later, or reports an exception for errored results.
// Optional feature macro: COMMIT_STALL_CNT_EN adds the 32-bit stall_cnt output.
module commit_arbiter
  import commit_arbiter_pkg::*;
#(
  parameter int  NUM_SRC    = COMMIT_NUM_SRC,
  parameter int  XLEN       = CORE_XLEN,
  parameter int  REG_ADDR_W = CORE_REG_ADDR_W,
  localparam int IDX_W      = $clog2(NUM_SRC)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_SRC-1:0]                  src_req,
  input  logic [NUM_SRC-1:0]                  src_valid,
  input  logic [NUM_SRC-1:0][XLEN-1:0]        src_res,
  input  logic [NUM_SRC-1:0][REG_ADDR_W-1:0]  src_rd,
  input  logic [NUM_SRC-1:0]                  src_error,
  output logic [NUM_SRC-1:0]                  src_clear,
  input  logic                                flush,
  output logic                                rf_we,
  output logic [REG_ADDR_W-1:0]               rf_waddr,
  output logic [XLEN-1:0]                     rf_wdata,
  output logic                                exc_valid,
  output logic [IDX_W-1:0]                    exc_src
`ifdef COMMIT_STALL_CNT_EN
  ,
  output logic [31:0]                         stall_cnt
`endif
);

  logic [IDX_W-1:0]   r_rr_ptr;
  logic [NUM_SRC-1:0] r_last_grant;
  logic               r_vld_p1;
  logic [NUM_SRC-1:0] r_clr_p1;
  commit_t            r_commit_p1;

  logic [NUM_SRC-1:0] w_elig;
  logic [NUM_SRC-1:0] w_gnt_oh;
  logic [IDX_W-1:0]   w_gnt_idx;
  logic               w_gnt_any;
  logic [IDX_W-1:0]   w_ptr_nxt;

  // ---- stage p0: eligibility and arbitration ----
  // The source granted last cycle still holds req while it samples clear,
  // so it is masked for one cycle to avoid a double commit.
  assign w_elig    = src_req & src_valid & ~r_last_grant;
  assign w_ptr_nxt = (w_gnt_idx == IDX_W'(NUM_SRC - 1)) ? '0 : w_gnt_idx + 1'b1;

  commit_arbiter_rr_arbiter #(
    .N     (NUM_SRC),
    .IDX_W (IDX_W)
  ) u_rr (
    .i_req     (w_elig),
    .i_ptr     (r_rr_ptr),
    .o_gnt_oh  (w_gnt_oh),
    .o_gnt_idx (w_gnt_idx),
    .o_gnt_any (w_gnt_any)
  );

  // Control state: grant valid, clear pulses, last-grant mask and pointer.
  // Flush drops every pending request in one shot and orders no new commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p1     <= 1'b0;
      r_clr_p1     <= '0;
      r_last_grant <= '0;
      r_rr_ptr     <= '0;
    end else if (flush) begin
      r_vld_p1     <= 1'b0;
      r_clr_p1     <= src_req;
      r_last_grant <= '0;
    end else begin
      r_vld_p1     <= w_gnt_any;
      r_clr_p1     <= w_gnt_oh;
      r_last_grant <= w_gnt_oh;
      if (w_gnt_any) begin
        r_rr_ptr <= w_ptr_nxt;
      end
    end
  end

  // Capture the granted source's result fields; only meaningful with r_vld_p1.
  always_ff @(posedge clk) begin
    r_commit_p1.rd    <= src_rd[w_gnt_idx];
    r_commit_p1.data  <= src_res[w_gnt_idx];
    r_commit_p1.error <= src_error[w_gnt_idx];
    r_commit_p1.src   <= COMMIT_SRC_W'(w_gnt_idx);
  end

  // ---- stage p1: register-file write / exception report ----
  // Writes to x0 are suppressed but the source is still cleared.
  assign src_clear = r_clr_p1;
  assign rf_we     = r_vld_p1 & ~r_commit_p1.error & (r_commit_p1.rd != '0);
  assign rf_waddr  = rf_we ? r_commit_p1.rd : '0;
  assign rf_wdata  = rf_we ? r_commit_p1.data : '0;
  assign exc_valid = r_vld_p1 & r_commit_p1.error;
  assign exc_src   = exc_valid ? IDX_W'(r_commit_p1.src) : '0;

`ifdef COMMIT_STALL_CNT_EN
  logic [31:0] r_stall_cnt;
  logic        w_stall;

  // A stall is any ready source (req & valid) left ungranted this cycle,
  // whether it lost arbitration or was masked.
  assign w_stall = |(src_req & src_valid & ~w_gnt_oh);

  // Free-running wrap-around stall counter, frozen while flushing.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (!flush && w_stall) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_commit_arbiter.sv
// Testbench for commit_arbiter: directed scenarios followed by random
// traffic, all checked cycle by cycle against a behavioural model.
// Build with COMMIT_STALL_CNT_EN to also cover the stall counter.
module tb_commit_arbiter;

  localparam int N = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst, flush;
  logic [N-1:0]        src_req, src_valid, src_error, src_clear;
  logic [N-1:0][31:0]  src_res;
  logic [N-1:0][4:0]   src_rd;
  logic                rf_we;
  logic [4:0]          rf_waddr;
  logic [31:0]         rf_wdata;
  logic                exc_valid;
  logic [2:0]          exc_src;
`ifdef COMMIT_STALL_CNT_EN
  logic [31:0]         stall_cnt;
`endif

  commit_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .src_req   (src_req),
    .src_valid (src_valid),
    .src_res   (src_res),
    .src_rd    (src_rd),
    .src_error (src_error),
    .src_clear (src_clear),
    .flush     (flush),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .exc_valid (exc_valid),
    .exc_src   (exc_src)
`ifdef COMMIT_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state: next-to-serve position, source masked after its
  // grant, and the expected stall count.
  int           m_ptr;
  logic [N-1:0] m_mask;
  logic [31:0]  m_cnt;

  // Expected outputs for the cycle after the current one.
  logic [N-1:0] e_clear;
  logic         e_we;
  logic [4:0]   e_waddr;
  logic [31:0]  e_wdata;
  logic         e_exc;
  logic [2:0]   e_src;

  logic [N-1:0] drop;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Predict the next cycle from the present inputs, advance one clock and
  // compare every output with the prediction.
  task automatic tick();
    int           g;
    logic [N-1:0] g_oh;
    g       = -1;
    g_oh    = '0;
    e_clear = '0;
    e_we    = 1'b0;
    e_waddr = '0;
    e_wdata = '0;
    e_exc   = 1'b0;
    e_src   = '0;
    if (rst) begin
      m_ptr  = 0;
      m_mask = '0;
      m_cnt  = '0;
    end else if (flush) begin
      e_clear = src_req;
      m_mask  = '0;
    end else begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (g < 0 && src_req[j] && src_valid[j] && !m_mask[j]) g = j;
      end
      if (g >= 0) begin
        g_oh[g] = 1'b1;
        e_clear = g_oh;
        m_ptr   = (g + 1) % N;
        if (src_error[g]) begin
          e_exc = 1'b1;
          e_src = 3'(g);
        end else if (src_rd[g] != 5'd0) begin
          e_we    = 1'b1;
          e_waddr = src_rd[g];
          e_wdata = src_res[g];
        end
      end
      m_mask = g_oh;
      if ((src_req & src_valid & ~g_oh) != '0) m_cnt = m_cnt + 32'd1;
    end
    @(posedge clk);
    #1;
    chk("src_clear", 32'(src_clear), 32'(e_clear));
    chk("rf_we",     32'(rf_we),     32'(e_we));
    chk("rf_waddr",  32'(rf_waddr),  32'(e_waddr));
    chk("rf_wdata",  rf_wdata,       e_wdata);
    chk("exc_valid", 32'(exc_valid), 32'(e_exc));
    chk("exc_src",   32'(exc_src),   32'(e_src));
`ifdef COMMIT_STALL_CNT_EN
    chk("stall_cnt", stall_cnt,      m_cnt);
`endif
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    src_req = '0; src_valid = '0; src_error = '0; src_res = '0; src_rd = '0;
    tick();
    chk("reset_clear", 32'(src_clear), 32'h0);
    chk("reset_we", 32'(rf_we), 32'h0);
    rst = 1'b0;

    // Single result from source 2.
    src_req = 5'b00100; src_valid = 5'b00100;
    src_rd[2] = 5'd5; src_res[2] = 32'hDEADBEEF;
    tick();
    chk("t1_we", 32'(rf_we), 32'h1);
    chk("t1_waddr", 32'(rf_waddr), 32'h5);
    chk("t1_wdata", rf_wdata, 32'hDEADBEEF);
    chk("t1_clear", 32'(src_clear), 32'h4);
    src_req = '0; src_valid = '0;
    tick();
    chk("t1_clear_once", 32'(src_clear), 32'h0);

    // Contention: every source pending from reset, each drops after its clear.
    rst = 1'b1; tick(); rst = 1'b0;
    src_req = 5'b11111; src_valid = 5'b11111; drop = '0;
    for (int i = 0; i < N; i++) begin
      src_rd[i]  = 5'(i + 10);
      src_res[i] = $urandom;
    end
    for (int k = 0; k < N; k++) begin
      tick();
      chk("t2_order", 32'(src_clear), 32'(1) << k);
      src_req = src_req & ~drop;
      drop    = src_clear;
    end
    src_req = 5'b11111;
    tick();
    chk("t2_wrap", 32'(src_clear), 32'h1);
    src_req = '0; src_valid = '0;
    tick();

    // Masking: source 1 keeps its request up.
    rst = 1'b1; tick(); rst = 1'b0;
    src_req = 5'b00010; src_valid = 5'b00010; src_rd[1] = 5'd3;
    tick(); chk("t3_c1", 32'(src_clear), 32'h2);
    tick(); chk("t3_c2", 32'(src_clear), 32'h0);
    tick(); chk("t3_c3", 32'(src_clear), 32'h2);
    src_req = '0; src_valid = '0;
    tick();

    // Errored result, then a write to x0.
    src_req = 5'b01000; src_valid = 5'b01000; src_error = 5'b01000; src_rd[3] = 5'd7;
    tick();
    chk("t4_we", 32'(rf_we), 32'h0);
    chk("t4_exc", 32'(exc_valid), 32'h1);
    chk("t4_exc_src", 32'(exc_src), 32'h3);
    src_error = '0;
    src_req = 5'b00001; src_valid = 5'b00001; src_rd[0] = 5'd0; src_res[0] = 32'h12345678;
    tick();
    chk("t4_x0_we", 32'(rf_we), 32'h0);
    chk("t4_x0_clear", 32'(src_clear), 32'h1);
    src_req = '0; src_valid = '0;
    tick();

    // Flush drops all pending; reset discards a registered commit.
    src_req = 5'b10001; src_valid = 5'b10001; flush = 1'b1;
    tick();
    chk("t5_flush_clear", 32'(src_clear), 32'h11);
    chk("t5_flush_we", 32'(rf_we), 32'h0);
    flush = 1'b0; src_req = '0; src_valid = '0;
    tick();
    src_req = 5'b00100; src_valid = 5'b00100; src_rd[2] = 5'd9; src_res[2] = 32'hCAFEF00D;
    tick();
    chk("t5_pre_we", 32'(rf_we), 32'h1);
    rst = 1'b1;
    tick();
    chk("t5_rst_clear", 32'(src_clear), 32'h0);
    chk("t5_rst_we", 32'(rf_we), 32'h0);
    chk("t5_rst_wdata", rf_wdata, 32'h0);
    rst = 1'b0; src_req = '0; src_valid = '0;
    tick();

`ifdef COMMIT_STALL_CNT_EN
    // Three sources held pending: at least one waits every cycle.
    rst = 1'b1; tick(); rst = 1'b0;
    src_req = 5'b00111; src_valid = 5'b00111;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t6_cnt", stall_cnt, 32'(k + 1));
    end
    force dut.r_stall_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.r_stall_cnt;
    m_cnt = 32'hFFFF_FFFF;
    tick();
    chk("t6_wrap", stall_cnt, 32'h0);
    flush = 1'b1;
    tick();
    chk("t6_flush_hold", stall_cnt, 32'h0);
    flush = 1'b0; src_req = '0; src_valid = '0;
    tick();
`endif

    // Random traffic.
    for (int c = 0; c < 400; c++) begin
      rst   = ($urandom_range(0, 63) == 0);
      flush = ($urandom_range(0, 15) == 0);
      for (int i = 0; i < N; i++) begin
        src_req[i]   = ($urandom_range(0, 3) != 0);
        src_valid[i] = ($urandom_range(0, 4) != 0);
        src_error[i] = ($urandom_range(0, 7) == 0);
        src_rd[i]    = 5'($urandom_range(0, 31));
        if ($urandom_range(0, 5) == 0) src_rd[i] = 5'd0;
        src_res[i]   = $urandom;
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
